// File: rtl/aes_pkg.sv
// Shared types and constants for the AES run sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_W = 128;
    localparam int CNT_W = 32;
    // Bank entry packing: {key, pt, ct}, expected ciphertext in the LSBs.
    localparam int VEC_W = 3 * AES_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } run_state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/aes_vec_mem.sv
// Vector bank: DEPTH x VEC_W RAM, one write port and one read port, no reset.
// Latency: 1 cycle read; rdat holds its value until the next read enable.
// Backpressure: none; write and read are accepted every cycle they are enabled.
// Ports: clk; we/waddr/wdat write port; re/raddr read request; rdat read data.
module aes_vec_mem
    import aes_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [VEC_W-1:0]         wdat,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [VEC_W-1:0]         rdat
);

    logic [VEC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
        if (re) begin
            rdat <= mem[raddr];
        end
    end

endmodule

// File: rtl/aes_run_ctrl.sv
// Sequencer feeding aescipher from an on-chip vector bank and scoring each result.
// Latency: run_i -> aes_start 2 cycles; 4 cycles per vector plus cipher latency.
// Backpressure: holds in ISSUE while aes_ready=0; bank writes only accepted when idle/done.
// Ports: clk/rst; run_i; vec_* bank write; aes_* cipher handshake; busy/done/trig and
//        pass/err counters, first_err_idx and timeout_err status.
module aes_run_ctrl
    import aes_pkg::*;
#(
    parameter int ITER_NUM   = 128,
    parameter int DEPTH      = 128,
    parameter int LOOP_FIXED = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run_i,
    input  logic                     vec_we,
    input  logic [$clog2(DEPTH)-1:0] vec_addr,
    input  logic [AES_W-1:0]         vec_key,
    input  logic [AES_W-1:0]         vec_pt,
    input  logic [AES_W-1:0]         vec_ct,
    output logic [AES_W-1:0]         aes_key,
    output logic [AES_W-1:0]         aes_pt,
    output logic                     aes_start,
    input  logic                     aes_ready,
    input  logic                     aes_ok,
    input  logic [AES_W-1:0]         aes_ct,
    output logic                     busy,
    output logic                     done,
    output logic                     trig,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         first_err_idx,
    output logic                     timeout_err
);

    localparam int AW = $clog2(DEPTH);

    run_state_t       state, state_nxt;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] to_cnt;
    logic             ok_q;
    logic             loaded;
    logic [AES_W-1:0] ct_cap;
    logic [VEC_W-1:0] rd_dat;
    logic [AW-1:0]    rd_addr;
    logic             ok_rise;
    logic             to_hit;
    logic             last_vec;
    logic             ct_match;
    logic             bank_we;

    // Only a fresh 0->1 edge counts, so a level left over from the previous
    // result (or from before a reset) can never complete a new vector.
    assign ok_rise  = aes_ok & ~ok_q;
    assign to_hit   = (to_cnt == CNT_W'(TIMEOUT - 1));
    assign last_vec = (idx == CNT_W'(ITER_NUM - 1));
    assign rd_addr  = (LOOP_FIXED != 0) ? '0 : idx[AW-1:0];
    assign ct_match = (ct_cap == rd_dat[AES_W-1:0]);
    assign bank_we  = vec_we && ((state == IDLE) || (state == DONE));

    aes_vec_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (bank_we),
        .waddr (vec_addr),
        .wdat  ({vec_key, vec_pt, vec_ct}),
        .re    (state == LOAD),
        .raddr (rd_addr),
        .rdat  (rd_dat)
    );

    // The RAM output register doubles as the key/pt holding register: it is
    // only reloaded in LOAD. 'loaded' masks the unreset RAM output to zero
    // until the first read after reset.
    assign aes_key = loaded ? rd_dat[VEC_W-1 -: AES_W]   : '0;
    assign aes_pt  = loaded ? rd_dat[2*AES_W-1 -: AES_W] : '0;

    assign busy = (state == LOAD) || (state == ISSUE) || (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);
    assign trig = (state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        aes_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (run_i) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = ISSUE;
            end
            ISSUE: begin
                if (aes_ready) begin
                    aes_start = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (ok_rise) begin
                    state_nxt = CHECK;
                end else if (to_hit) begin
                    state_nxt = DONE;
                end
            end
            CHECK: begin
                state_nxt = last_vec ? DONE : LOAD;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            to_cnt        <= '0;
            ok_q          <= 1'b0;
            loaded        <= 1'b0;
            ct_cap        <= '0;
            pass_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= '1;
            timeout_err   <= 1'b0;
        end else begin
            ok_q <= aes_ok;
            case (state)
                IDLE, DONE: begin
                    if (run_i) begin
                        idx           <= '0;
                        pass_cnt      <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= '1;
                        timeout_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    loaded <= 1'b1;
                end
                ISSUE: begin
                    to_cnt <= '0;
                end
                WAIT: begin
                    if (ok_rise) begin
                        ct_cap <= aes_ct;
                    end else if (to_hit) begin
                        err_cnt     <= sat_inc(err_cnt);
                        timeout_err <= 1'b1;
                        if (&first_err_idx) begin
                            first_err_idx <= idx;
                        end
                    end else begin
                        to_cnt <= sat_inc(to_cnt);
                    end
                end
                CHECK: begin
                    if (ct_match) begin
                        pass_cnt <= sat_inc(pass_cnt);
                    end else begin
                        err_cnt <= sat_inc(err_cnt);
                        if (&first_err_idx) begin
                            first_err_idx <= idx;
                        end
                    end
                    if (!last_vec) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_run_ctrl.sv
// Directed bench for aes_run_ctrl: three instances (single vector, 4-vector, fixed loop)
// Latency: n/a (bench); cipher stubs answer a fixed number of cycles after aes_start.
// Backpressure: aes_ready driven per instance by the stimulus.
module tb_aes_run_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] FK   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [31:0]  NONE = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         run [3];
    logic         we [3];
    logic         rdy [3];
    logic [2:0]   wa;
    logic [127:0] wk, wp, wc;
    logic [127:0] a_key [3];
    logic [127:0] a_pt [3];
    logic [127:0] a_ct [3];
    logic         a_start [3];
    logic         a_ok [3];
    logic         busy [3];
    logic         done [3];
    logic         trig [3];
    logic [31:0]  pass [3];
    logic [31:0]  errc [3];
    logic [31:0]  fei [3];
    logic         toe [3];

    // Stand-in cipher: real answer for the FIPS-197 vector, a cheap mix otherwise.
    function automatic logic [127:0] fake_ct(input logic [127:0] k, input logic [127:0] p);
        if (k == FK && p == FP) return FC;
        return k ^ {p[63:0], p[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] vk(input int i);
        return {4{32'hA5A5_0000 + 32'(i)}};
    endfunction

    function automatic logic [127:0] vp(input int i);
        return {4{32'h3C3C_0100 + 32'(i * 3)}};
    endfunction

    aes_run_ctrl #(.ITER_NUM(1), .DEPTH(4), .LOOP_FIXED(0), .TIMEOUT(16)) u0 (
        .clk(clk), .rst(rst), .run_i(run[0]), .vec_we(we[0]), .vec_addr(wa[1:0]),
        .vec_key(wk), .vec_pt(wp), .vec_ct(wc), .aes_key(a_key[0]), .aes_pt(a_pt[0]),
        .aes_start(a_start[0]), .aes_ready(rdy[0]), .aes_ok(a_ok[0]), .aes_ct(a_ct[0]),
        .busy(busy[0]), .done(done[0]), .trig(trig[0]), .pass_cnt(pass[0]),
        .err_cnt(errc[0]), .first_err_idx(fei[0]), .timeout_err(toe[0]));

    aes_run_ctrl #(.ITER_NUM(4), .DEPTH(8), .LOOP_FIXED(0), .TIMEOUT(16)) u1 (
        .clk(clk), .rst(rst), .run_i(run[1]), .vec_we(we[1]), .vec_addr(wa),
        .vec_key(wk), .vec_pt(wp), .vec_ct(wc), .aes_key(a_key[1]), .aes_pt(a_pt[1]),
        .aes_start(a_start[1]), .aes_ready(rdy[1]), .aes_ok(a_ok[1]), .aes_ct(a_ct[1]),
        .busy(busy[1]), .done(done[1]), .trig(trig[1]), .pass_cnt(pass[1]),
        .err_cnt(errc[1]), .first_err_idx(fei[1]), .timeout_err(toe[1]));

    aes_run_ctrl #(.ITER_NUM(128), .DEPTH(4), .LOOP_FIXED(1), .TIMEOUT(16)) u2 (
        .clk(clk), .rst(rst), .run_i(run[2]), .vec_we(we[2]), .vec_addr(wa[1:0]),
        .vec_key(wk), .vec_pt(wp), .vec_ct(wc), .aes_key(a_key[2]), .aes_pt(a_pt[2]),
        .aes_start(a_start[2]), .aes_ready(rdy[2]), .aes_ok(a_ok[2]), .aes_ct(a_ct[2]),
        .busy(busy[2]), .done(done[2]), .trig(trig[2]), .pass_cnt(pass[2]),
        .err_cnt(errc[2]), .first_err_idx(fei[2]), .timeout_err(toe[2]));

    // Cipher stubs and event monitors. The stubs ignore rst on purpose so a
    // result can arrive after the sequencer has been reset.
    int           t [3];
    int           lat [3];
    int           hold [3];
    bit           hang [3];
    logic [127:0] sk [3];
    logic [127:0] sp [3];
    int           nstart [3];
    int           ntrig [3];
    int           nbad [3];
    logic         trig_q [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            trig_q[i] <= trig[i];
            if (trig[i] && !trig_q[i]) ntrig[i] <= ntrig[i] + 1;
            if (a_start[i]) begin
                t[i]      <= 1;
                sk[i]     <= a_key[i];
                sp[i]     <= a_pt[i];
                nstart[i] <= nstart[i] + 1;
                if (a_key[i] !== FK || a_pt[i] !== FP) nbad[i] <= nbad[i] + 1;
            end else if (t[i] != 0) begin
                t[i] <= (t[i] >= lat[i] + hold[i]) ? 0 : t[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            a_ok[i] = !hang[i] && (t[i] > lat[i]) && (t[i] <= lat[i] + hold[i]);
            a_ct[i] = fake_ct(sk[i], sp[i]);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int u, input logic [2:0] a, input logic [127:0] k,
                      input logic [127:0] p, input logic [127:0] c);
        @(negedge clk);
        we[u] = 1'b1; wa = a; wk = k; wp = p; wc = c;
        @(negedge clk);
        we[u] = 1'b0;
    endtask

    task automatic go(input int u);
        @(negedge clk);
        run[u] = 1'b1;
        @(negedge clk);
        run[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, input int budget, input string tag);
        int k = 0;
        while (!done[u] && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_in_time"}, 128'(done[u]), 128'(1));
    endtask

    task automatic wait_trig(input int u, input string tag);
        int k = 0;
        while (!trig[u] && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reach_wait"}, 128'(trig[u]), 128'(1));
    endtask

    logic [127:0] c;
    int s0, tr0, b0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            run[i] = 1'b0; we[i] = 1'b0; rdy[i] = 1'b1;
            lat[i] = 2; hold[i] = 1; hang[i] = 1'b0;
        end
        wa = '0; wk = '0; wp = '0; wc = '0;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        // Reset state
        check("rst_busy",  128'(busy[1]),    128'(0));
        check("rst_done",  128'(done[1]),    128'(0));
        check("rst_trig",  128'(trig[1]),    128'(0));
        check("rst_start", 128'(a_start[1]), 128'(0));
        check("rst_pass",  128'(pass[1]),    128'(0));
        check("rst_err",   128'(errc[1]),    128'(0));
        check("rst_fei",   128'(fei[1]),     128'(NONE));
        check("rst_toe",   128'(toe[1]),     128'(0));
        check("rst_key",   a_key[1],         128'(0));

        // Single FIPS-197 vector, cycle-exact start/trig timing
        wr(0, 3'd0, FK, FP, FC);
        lat[0] = 3;
        @(negedge clk); run[0] = 1'b1;          // cycle t
        @(negedge clk); run[0] = 1'b0;          // t+1: LOAD
        check("t1_load_busy",  128'(busy[0]),    128'(1));
        check("t1_no_start_t1", 128'(a_start[0]), 128'(0));
        @(negedge clk);                          // t+2: ISSUE
        check("t1_start_t2", 128'(a_start[0]), 128'(1));
        check("t1_key",      a_key[0],         FK);
        check("t1_pt",       a_pt[0],          FP);
        check("t1_trig_low", 128'(trig[0]),    128'(0));
        @(negedge clk);                          // t+3: WAIT
        check("t1_trig_t3",  128'(trig[0]),    128'(1));
        check("t1_start_1x", 128'(a_start[0]), 128'(0));
        wait_done(0, 50, "t1");
        check("t1_pass", 128'(pass[0]), 128'(1));
        check("t1_err",  128'(errc[0]), 128'(0));
        check("t1_fei",  128'(fei[0]),  128'(NONE));
        check("t1_busy", 128'(busy[0]), 128'(0));

        // Four vectors, entry 2 expected value with bit 0 flipped
        for (int i = 0; i < 4; i++) begin
            c = fake_ct(vk(i), vp(i));
            if (i == 2) c[0] = ~c[0];
            wr(1, 3'(i), vk(i), vp(i), c);
        end
        go(1);
        wait_done(1, 200, "t2");
        check("t2_pass", 128'(pass[1]), 128'(3));
        check("t2_err",  128'(errc[1]), 128'(1));
        check("t2_fei",  128'(fei[1]),  128'(2));
        check("t2_toe",  128'(toe[1]),  128'(0));

        // Fixed loop: entry 1 holds garbage and must never be used
        wr(2, 3'd0, FK, FP, FC);
        wr(2, 3'd1, 128'hdeadbeef_00000000_cafef00d_11111111,
                    128'h12345678_9abcdef0_0fedcba9_87654321, 128'h0);
        lat[2] = 1;
        s0 = nstart[2]; tr0 = ntrig[2]; b0 = nbad[2];
        go(2);
        wait_done(2, 3000, "t3");
        check("t3_pass",   128'(pass[2]),          128'(128));
        check("t3_err",    128'(errc[2]),          128'(0));
        check("t3_starts", 128'(nstart[2] - s0),   128'(128));
        check("t3_trigs",  128'(ntrig[2] - tr0),   128'(128));
        check("t3_badkey", 128'(nbad[2] - b0),     128'(0));

        // Cipher not ready for ~50 cycles, then hangs
        rdy[1] = 1'b0; hang[1] = 1'b1;
        s0 = nstart[1];
        go(1);
        cyc(48);
        check("t4_no_start", 128'(nstart[1] - s0), 128'(0));
        check("t4_busy",     128'(busy[1]),        128'(1));
        check("t4_no_trig",  128'(trig[1]),        128'(0));
        rdy[1] = 1'b1;
        #1;                                      // cycle s
        check("t4_start_on_ready", 128'(a_start[1]), 128'(1));
        cyc(16);                                 // s+16
        check("t4_not_done_yet", 128'(done[1]), 128'(0));
        cyc(1);                                  // s+17
        check("t4_done", 128'(done[1]), 128'(1));
        check("t4_toe",  128'(toe[1]),  128'(1));
        check("t4_err",  128'(errc[1]), 128'(1));
        check("t4_pass", 128'(pass[1]), 128'(0));
        check("t4_fei",  128'(fei[1]),  128'(0));

        // Held aes_ok and a bank write attempted during WAIT
        hang[1] = 1'b0; lat[1] = 4; hold[1] = 3;
        wr(1, 3'd2, vk(2), vp(2), fake_ct(vk(2), vp(2)));
        go(1);
        wait_trig(1, "t5");
        wr(1, 3'd0, 128'h0, 128'h0, 128'h1);
        wait_done(1, 200, "t5");
        check("t5_pass", 128'(pass[1]), 128'(4));
        check("t5_err",  128'(errc[1]), 128'(0));
        check("t5_fei",  128'(fei[1]),  128'(NONE));
        go(1);
        wait_done(1, 200, "t5b");
        check("t5_bank_intact_pass", 128'(pass[1]), 128'(4));
        check("t5_bank_intact_err",  128'(errc[1]), 128'(0));

        // Reset during WAIT; the stub's late answer must be ignored
        lat[1] = 6; hold[1] = 1;
        go(1);
        wait_trig(1, "t6");
        cyc(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        check("t6_busy", 128'(busy[1]), 128'(0));
        check("t6_done", 128'(done[1]), 128'(0));
        check("t6_trig", 128'(trig[1]), 128'(0));
        check("t6_pass", 128'(pass[1]), 128'(0));
        check("t6_err",  128'(errc[1]), 128'(0));
        check("t6_fei",  128'(fei[1]),  128'(NONE));
        check("t6_key",  a_key[1],      128'(0));
        cyc(10);
        check("t6_late_busy", 128'(busy[1]), 128'(0));
        check("t6_late_pass", 128'(pass[1]), 128'(0));
        check("t6_late_err",  128'(errc[1]), 128'(0));
        go(1);
        wait_done(1, 200, "t6");
        check("t6_rerun_pass", 128'(pass[1]), 128'(4));
        check("t6_rerun_err",  128'(errc[1]), 128'(0));
        check("t6_rerun_toe",  128'(toe[1]),  128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_run_ctrl.md
# aes_run_ctrl

Hardware sequencer that sits directly upstream of `aescipher`. It holds a small on-chip bank of {key, plaintext, expected ciphertext} vectors, issues them one at a time to the cipher, and waits for completion. It then compares the cipher output against the expected value and keeps pass/error counts. It replaces the bench-side vector loop so that long encryption runs (including fixed-vector loops for power analysis) run on-chip with a clean trigger.

## Interface
Parameters:
- `ITER_NUM`, 128: vectors (or loop iterations) per run, ≥1.
- `DEPTH`, 128: vector bank entries, power of two, ≥ `ITER_NUM` unless `LOOP_FIXED`=1.
- `LOOP_FIXED`, 0: 1 means every iteration uses entry 0.
- `TIMEOUT`, 1024: maximum cycles from `aes_start` to the `aes_ok` rising edge.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`, in, 1: clock.
  - `rst`, in, 1: asynchronous active-high reset.
- Run control:
  - `run_i`, in, 1: one-cycle pulse that starts a run.
- Vector bank write port:
  - `vec_we`, in, 1: bank write enable.
  - `vec_addr`, in, $clog2(DEPTH): bank write address.
  - `vec_key`, in, 128: key to write.
  - `vec_pt`, in, 128: plaintext to write.
  - `vec_ct`, in, 128: expected ciphertext to write.
- Cipher interface:
  - `aes_key`, out, 128: key to the cipher.
  - `aes_pt`, out, 128: plaintext to the cipher.
  - `aes_start`, out, 1: one-cycle issue pulse.
  - `aes_ready`, in, 1: cipher can accept an issue.
  - `aes_ok`, in, 1: cipher result valid; may stay high for more than one cycle.
  - `aes_ct`, in, 128: cipher output.
- Status:
  - `busy`, out, 1: run in progress.
  - `done`, out, 1: run finished; sticky.
  - `trig`, out, 1: high while the cipher is computing.
  - `pass_cnt`, out, 32: matching results in this run.
  - `err_cnt`, out, 32: mismatches plus timeouts in this run.
  - `first_err_idx`, out, 32: index of the first error; all-ones if none.
  - `timeout_err`, out, 1: sticky timeout flag.

## Operation
States: IDLE, LOAD, ISSUE, WAIT, CHECK, DONE.

- **IDLE:**
  - `run_i` clears `pass_cnt`, `err_cnt`, `timeout_err` and `done`, sets `idx`=0 and `first_err_idx`=all-ones, then moves to LOAD.
  - `vec_we` writes the bank only in IDLE or DONE. Writes in any other state are dropped silently.
- **LOAD:** synchronous bank read of address `LOOP_FIXED ? 0 : idx`. Next state ISSUE.
- **ISSUE:**
  - `aes_key`/`aes_pt` are registered from read data on entry.
  - `aes_start`=1 in the first ISSUE cycle where `aes_ready`=1, then WAIT.
  - With `aes_ready`=0, the block waits in ISSUE indefinitely with `aes_start`=0.
- **WAIT:**
  - `trig`=1.
  - A timeout counter starts at 0 on entry.
  - Only a 0→1 edge of `aes_ok` is accepted. An `aes_ok` level already high on WAIT entry is ignored until it drops.
  - Rising edge of `aes_ok` → CHECK; `aes_ct` is captured in the same cycle.
  - Counter reaching `TIMEOUT`-1 → DONE, with `err_cnt`+1, `timeout_err`=1, and `first_err_idx`=`idx` if it was still unset.
- **CHECK:**
  - Captured ct == expected ct → `pass_cnt`+1.
  - Mismatch → `err_cnt`+1, and `first_err_idx`=`idx` if it is still all-ones.
  - If `idx`==`ITER_NUM`-1 → DONE; otherwise `idx`+1 → LOAD.
- **DONE:** `done`=1 and `busy`=0. `run_i` starts a new run exactly as from IDLE.

Other rules:
- `run_i` while `busy` is ignored.
- `busy`=1 in LOAD, ISSUE, WAIT and CHECK.
- All counters are 32-bit unsigned and saturate at all-ones; they never wrap.
- `aes_key` and `aes_pt` hold their value from ISSUE until the next LOAD.
- Reset:
  - FSM goes to IDLE; all outputs, counters and flags go to 0, except `first_err_idx`=all-ones.
  - Bank contents are not reset.
  - Reset mid-WAIT abandons the cipher operation; a late `aes_ok` arriving in IDLE is ignored.

## Timing
- `run_i` sampled at cycle t → LOAD at t+1 → ISSUE at t+2.
- With `aes_ready`=1, `aes_start` is high at t+2 and WAIT begins at t+3.
- `aes_ok` rising edge sampled at cycle w → CHECK at w+1, with counters updated at the end of w+1.
- Next LOAD is at w+2, or DONE at w+2.
- Per-vector overhead is 4 cycles plus cipher latency.
- `trig` rises at t+3 and falls when CHECK is entered.
- `aes_start` is never high in two consecutive cycles.

## Structure
- `aes_pkg` holds:
  - the state enum `run_state_t`;
  - the width constants `AES_W`=128 and `CNT_W`=32;
  - the `VEC_W`=384 packing order {key, pt, ct}, with ct in the LSBs.
- Sub-module `aes_vec_mem`: single-port-write / single-port-read synchronous RAM, `DEPTH`×384, with 1-cycle read latency and no reset.
- The FSM, counters and compare stay in `aes_run_ctrl`.

## Test plan
1. **Single pass:**
   - Stimulus: entry 0 = key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, ct 69c4e0d86a7b0430d8cdb78070b4c55a; `ITER_NUM`=1; `run_i`.
   - Required response: `aes_start` at t+2, `pass_cnt`=1, `err_cnt`=0, `done`=1, `first_err_idx`=FFFFFFFF.
2. **Corrupted expected value:**
   - Stimulus: entries 0..3 valid, entry 2 ct with bit 0 flipped; `ITER_NUM`=4.
   - Required response: `pass_cnt`=3, `err_cnt`=1, `first_err_idx`=2.
3. **Fixed loop:**
   - Stimulus: `LOOP_FIXED`=1, `ITER_NUM`=128, entry 1 filled with garbage.
   - Required response: 128 `aes_start` pulses, all with entry-0 key/pt; `pass_cnt`=128; exactly 128 `trig` pulses.
4. **Cipher not ready, then hung:**
   - Stimulus: hold `aes_ready`=0 for 50 cycles, then release; stub never raises `aes_ok`; `TIMEOUT`=16.
   - Required response: no `aes_start` while `aes_ready`=0. `done` and `timeout_err` are set 16 cycles after `aes_start`, with `err_cnt`=1.
5. **Held `aes_ok` and mid-run bank write:**
   - Stimulus: hold `aes_ok` high 3 cycles per result; issue a `vec_we` during WAIT.
   - Required response: one count per vector; the bank is unchanged.
6. **Reset mid-WAIT:**
   - Stimulus: assert `rst` for 1 cycle during WAIT, with a late `aes_ok` arriving afterwards.
   - Required response: IDLE; all counters 0; the late `aes_ok` is ignored. A following `run_i` then completes normally.
